// File: rtl/lsu_if.sv
// Core-side and data-memory-side signals of the load/store unit.
// The slave modport is the LSU itself. The master modport is the core and memory environment.
interface lsu_if;
    logic        op_valid;
    logic        op_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport slave (
        input  op_valid, op_we, funct3, addr, wdata, mem_ready, mem_rdata, mem_err,
        output stall, done, fault, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output op_valid, op_we, funct3, addr, wdata, mem_ready, mem_rdata, mem_err,
        input  stall, done, fault, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one req/ready memory transaction per instruction, with byte-lane steering,
// load extension and fault reporting.
//   state | meaning
//   IDLE  | waiting for op_valid; illegal ops fault here with zero latency
//   REQ   | mem_req held with stable mem_* until mem_ready or timeout
//   DONE  | one-cycle done (and fault) pulse, then back to IDLE
module lsu #(
    parameter int TIMEOUT = 16
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic        mem_req_q, mem_we_q, done_q, fault_q;
    logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
    logic [3:0]  mem_be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        legal, illegal_now;
    logic [3:0]  be_n;
    logic [31:0] wd_n, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        legal = 1'b0;
        case (bus.funct3)
            3'b000:         legal = 1'b1;
            3'b001:         legal = ~bus.addr[0];
            3'b010:         legal = (bus.addr[1:0] == 2'b00);
            3'b100:         legal = ~bus.op_we;
            3'b101:         legal = ~bus.op_we & ~bus.addr[0];
            default:        legal = 1'b0;
        endcase
    end

    always_comb begin
        be_n = 4'hF;
        wd_n = bus.wdata;
        if (bus.op_we) begin
            case (bus.funct3[1:0])
                2'b00: begin
                    be_n = 4'b0001 << bus.addr[1:0];
                    wd_n = {4{bus.wdata[7:0]}};
                end
                2'b01: begin
                    be_n = bus.addr[1] ? 4'b1100 : 4'b0011;
                    wd_n = {2{bus.wdata[15:0]}};
                end
                default: begin
                    be_n = 4'hF;
                    wd_n = bus.wdata;
                end
            endcase
        end
    end

    // Extraction uses the lane and width latched at acceptance, not the live core inputs.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    if (bus.op_valid && legal) begin
                        state       <= REQ;
                        cnt         <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.op_we;
                        mem_addr_q  <= {bus.addr[31:2], 2'b00};
                        mem_be_q    <= be_n;
                        mem_wdata_q <= wd_n;
                        f3_q        <= bus.funct3;
                        off_q       <= bus.addr[1:0];
                    end
                end
                REQ: begin
                    // mem_ready takes priority over a timeout landing in the same cycle.
                    if (bus.mem_ready) begin
                        state     <= DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        fault_q   <= bus.mem_err;
                        if (!mem_we_q && !bus.mem_err)
                            rdata_q <= ld_ext;
                    end else if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        fault_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign illegal_now   = rst_n & (state == IDLE) & bus.op_valid & ~legal;
    assign bus.stall     = rst_n & (((state == IDLE) & bus.op_valid & legal) | (state == REQ));
    assign bus.done      = done_q | illegal_now;
    assign bus.fault     = fault_q | illegal_now;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle core. It sits directly downstream of the ALU: it takes the ALU result as the effective address and the rs2 value as store data. It runs a req/ready transaction to data memory, applies RISC-V byte-lane steering and load sign/zero extension, and stalls the core until the access completes. Misaligned, illegal and timed-out accesses raise a one-cycle `fault` pulse instead of hanging the pipeline.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles in REQ without `mem_ready` before the access is abandoned; must be ≥1.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `op_valid`  in  1: core presents a memory instruction this cycle.
- `op_we`  in  1: 1 = store, 0 = load.
- `funct3`  in  3: RV32I width code.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- `addr`  in  32: effective address (ALU `out`).
- `wdata`  in  32: store data (rs2).
- `stall`  out  1: hold PC and register write-back.
- `done`  out  1: one-cycle pulse; access finished (success or fault).
- `fault`  out  1: one-cycle pulse; misaligned, illegal funct3, bus error or timeout.
- `rdata`  out  32: extended load result.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: memory write.
- `mem_addr`  out  32: word address, `{addr[31:2],2'b00}`.
- `mem_be`  out  4: byte enables.
- `mem_wdata`  out  32: lane-steered store data.
- `mem_ready`  in  1: memory completes the request this cycle.
- `mem_rdata`  in  32: read word, valid with `mem_ready`.
- `mem_err`  in  1: bus error, qualified by `mem_ready`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If `op_valid` and the access is legal: latch the memory outputs, latch funct3/`addr[1:0]`/`op_we`, go to REQ.
  - If `op_valid` and the access is illegal: stay in IDLE and pulse `fault` and `done` combinationally; `stall`=0; no request is issued.
- Legality:
  - funct3 ∈ {000,001,010,100,101} for loads; funct3 ∈ {000,001,010} for stores.
  - Half accesses require `addr[0]`=0; word accesses require `addr[1:0]`=0.
- REQ:
  - `mem_req`=1; all `mem_*` outputs held stable.
  - Wait counter increments each cycle `mem_ready`=0.
  - On `mem_ready`=1 go to DONE. For a load with `mem_err`=0, register the extended `rdata`.
  - If `mem_ready`=0 and the counter has reached `TIMEOUT`−1, go to DONE with a fault flag set.
- DONE: `done`=1; `fault`=1 if `mem_err` or timeout was flagged; `stall`=0; unconditional transition to IDLE.
- `stall` = (IDLE & `op_valid` & legal) | REQ.
- Byte lanes, with off = `addr[1:0]`:
  - SB: `mem_be` = 0001<<off; `mem_wdata` = {4{wdata[7:0]}}.
  - SH: `mem_be` = 0011<<{off[1],0}; `mem_wdata` = {2{wdata[15:0]}}.
  - SW: `mem_be` = 1111; `mem_wdata` = `wdata`.
  - Loads: `mem_be` = 1111.
- Load extraction: the byte/half is taken from `mem_rdata` at lane off. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- `rdata` is unchanged by stores, faults and timeouts; it holds its value until the next successful load.
- Precedence and edge cases:
  - `mem_ready` in the same cycle the timeout would fire: `mem_ready` wins and there is no timeout.
  - `mem_ready` outside REQ is ignored.
  - `op_valid` in REQ or DONE is ignored. The core holds the instruction while `stall`=1 and advances after DONE.

## Timing
- Reset values: state IDLE, counter 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_be` 0, `mem_wdata` 0, `rdata` 0, `done` 0, `fault` 0.
- `stall` is 0 during reset.
- Reset asserted mid-REQ drops `mem_req` asynchronously; no `done` pulse is generated.
- Legal access with `op_valid` at cycle 0:
  - `mem_req` rises at the cycle 1 edge.
  - Zero wait states (`mem_ready` in cycle 1): DONE in cycle 2; `stall` high in cycles 0–1.
  - General case, `mem_ready` first high in cycle k: DONE in cycle k+1; `rdata` valid from cycle k+1.
- Timeout with no `mem_ready`: REQ occupies cycles 1..TIMEOUT; DONE with `fault` follows in cycle TIMEOUT+1.
- Illegal access: zero latency; `fault` and `done` appear in the same cycle as `op_valid`.
- Back-to-back accesses: after DONE in cycle n, the earliest next acceptance is cycle n+1.

## Test plan
- LB, `addr`=0x1003, `mem_rdata`=0x80AA_BBCC, `mem_ready` at cycle 1 → `mem_be`=1111, `mem_addr`=0x1000; `rdata`=0xFFFF_FF80 in cycle 2; `done`=1 in cycle 2; `stall` high in cycles 0–1.
- SH, `addr`=0x2002, `wdata`=0x1234_5678 → `mem_be`=1100, `mem_wdata`=0x5678_5678, `mem_we`=1; `rdata` unchanged.
- LW, `addr`=0x3001 → `fault`=1 and `done`=1 in cycle 0; `mem_req` never asserted; `stall`=0.
- LHU, `addr`=0x4002, `mem_ready` delayed 5 cycles, `mem_rdata`=0xF00D_0000 → `mem_req` held with stable address/be; `rdata`=0x0000_F00D one cycle after ready.
- TIMEOUT=4, SW with no `mem_ready` → REQ for 4 cycles; `done`=`fault`=1 in cycle 5; `rdata` unchanged.
- Reset mid-REQ (`rst_n` low in cycle 2) → `mem_req`=0 immediately; after release, state is IDLE and a new LW completes normally.
